memory_controller: RTL and testbench
====================================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have parameter N_CORES, default 4, number of core lanes.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port MRead  in  1  read request.
REQ-006 SHALL have port MWrite  in  1  write request.
REQ-007 SHALL have port MReady  out  1  high when idle and able to accept a request.
REQ-008 SHALL have port en  in  N_CORES  per-lane enable.
REQ-009 SHALL have port addr  in  N_CORES x ADDR_W  per-lane address (unpacked array).
REQ-010 SHALL have port data  in  N_CORES x DATA_W  per-lane write data.
REQ-011 SHALL have port q  out  N_CORES x DATA_W  per-lane read result, registered.
REQ-012 SHALL have port data_to_mem  out  DATA_W  write data to the DataMemory.
REQ-013 SHALL have port addr_mem  out  ADDR_W  address to the DataMemory.
REQ-014 SHALL have port data_from_mem  in  DATA_W  read data from the DataMemory.
REQ-015 SHALL have port wren  out  1  DataMemory write enable.

Function
REQ-016 States: IDLE, READ, WRITE. MReady SHALL be 1 exactly when in IDLE.
REQ-017 In IDLE, request sampling:
- MWrite=1 at a rising edge SHALL latch en, addr and data and enter WRITE.
- Otherwise, MRead=1 SHALL latch the same inputs and enter READ.
- MWrite SHALL win when both are high.
REQ-018 Requests while in READ or WRITE SHALL be ignored and not queued.
REQ-019 In READ/WRITE a lane index idx SHALL step from the first lane to lane N_CORES-1, one lane per cycle.
REQ-020 In each such cycle:
- addr_mem SHALL equal latched addr[idx].
- data_to_mem SHALL equal latched data[idx].
- wren SHALL equal (state==WRITE && latched en[idx]).
REQ-021 The DataMemory is clocked on the inverted clk, so read data SHALL be valid at the next rising edge.
REQ-022 In READ, at the end of the lane cycle, q[idx] SHALL load data_from_mem if latched en[idx]=1; otherwise q[idx] SHALL hold.
REQ-023 After the last lane cycle the FSM SHALL return to IDLE, with MReady high in the following cycle.
REQ-024 In IDLE: wren=0, addr_mem=0, data_to_mem=0.
REQ-025 q lanes not read SHALL hold their values indefinitely.
REQ-026 All-lanes-disabled request: no memory write SHALL occur and q SHALL be unchanged; lane scheduling follows REQ-030.

Reset
REQ-027 Reset SHALL apply on a rising edge while reset=1 and override any request.
REQ-028 Reset SHALL set state=IDLE, idx=0, all q=0 and all latched registers=0.
REQ-029 Reset mid-operation SHALL abort it immediately: remaining lanes are not accessed, and wren=0 from the following cycle.

Configuration
REQ-030 Macro SKIP_DISABLED_LANES_EN selects lane scheduling:
- Defined: the FSM SHALL visit only enabled lanes in ascending order, so busy time equals popcount(en) cycles, and an all-zero en returns to IDLE after one cycle.
- Undefined: every lane SHALL be visited, so busy time is always N_CORES cycles.

Structure
REQ-031 A shared package SHALL hold N_CORES, DATA_W, ADDR_W, CLK_PERIOD and the state encoding.
REQ-032 Lane selection (next enabled index at or after a given index) SHALL be a sub-module named next_lane_sel, used when SKIP_DISABLED_LANES_EN is defined.
REQ-033 DataMemory SHALL stay an external module instantiated beside the controller and clocked by ~clk.

Verification
REQ-034 Preload mem[11]=0x1111 and mem[12]=0x2222; en=0110, addr=10,11,12,13; pulse MRead for 1 cycle -> q[1]=0x1111, q[2]=0x2222, q[0]=q[3]=0, wren never 1, MReady low for 4 cycles (2 with macro).
REQ-035 en=1111, addr=20..23, data=9,20,55,24; pulse MWrite -> mem[20..23]=9,20,55,24; a subsequent read returns these in q[0..3].
REQ-036 MRead and MWrite high in the same IDLE cycle -> a write is performed and q is unchanged.
REQ-037 MRead pulsed again while busy -> ignored; exactly one operation completes.
REQ-038 reset asserted during the 2nd lane of a write with en=1111 -> only lane 0 is written, IDLE and MReady=1 next cycle, all q=0.
REQ-039 en=0000 with MWrite -> no memory change, MReady returns high (after 4 cycles without the macro, 1 with it).

Source files
------------

// File: rtl/memory_controller_pkg.sv
// rtl/memory_controller_pkg.sv - shared sizes, clock period and FSM encoding for memory_controller
package memory_controller_pkg;

  localparam int N_CORES    = 4;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 16;
  localparam int CLK_PERIOD = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/memory_controller_next_lane_sel.sv
// rtl/memory_controller_next_lane_sel.sv - lowest set lane in mask at or after start (lane=0 when none)
module next_lane_sel #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W:0]   start,
  output logic             found,
  output logic [IDX_W-1:0] lane
);

  // Descending scan so the lowest qualifying lane is the last one written.
  always_comb begin
    found = 1'b0;
    lane  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && ((IDX_W + 1)'(i) >= start)) begin
        found = 1'b1;
        lane  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - multi-lane DataMemory sequencer; SKIP_DISABLED_LANES_EN skips disabled lanes
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int N_CORES = memory_controller_pkg::N_CORES,
  parameter int DATA_W  = memory_controller_pkg::DATA_W,
  parameter int ADDR_W  = memory_controller_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MRead,
  input  logic               MWrite,
  output logic               MReady,
  input  logic [N_CORES-1:0] en,
  input  logic [ADDR_W-1:0]  addr [N_CORES],
  input  logic [DATA_W-1:0]  data [N_CORES],
  output logic [DATA_W-1:0]  q [N_CORES],
  output logic [DATA_W-1:0]  data_to_mem,
  output logic [ADDR_W-1:0]  addr_mem,
  input  logic [DATA_W-1:0]  data_from_mem,
  output logic               wren
);

  localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [N_CORES-1:0] en_r;
  logic [ADDR_W-1:0]  addr_r [N_CORES];
  logic [DATA_W-1:0]  data_r [N_CORES];

  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   next_idx;
  logic               last_lane;

`ifdef SKIP_DISABLED_LANES_EN
  logic             first_found;
  logic             more_found;
  logic [IDX_W-1:0] first_lane;
  logic [IDX_W:0]   scan_start;

  assign scan_start = {1'b0, idx} + (IDX_W + 1)'(1);

  next_lane_sel #(.N(N_CORES), .IDX_W(IDX_W)) u_first_sel (
    .mask  (en),
    .start ('0),
    .found (first_found),
    .lane  (first_lane)
  );

  next_lane_sel #(.N(N_CORES), .IDX_W(IDX_W)) u_next_sel (
    .mask  (en_r),
    .start (scan_start),
    .found (more_found),
    .lane  (next_idx)
  );

  // An all-disabled request still spends one idle lane cycle at lane 0.
  assign first_idx = first_found ? first_lane : '0;
  assign last_lane = !more_found;
`else
  assign first_idx = '0;
  assign next_idx  = idx + IDX_W'(1);
  assign last_lane = (idx == IDX_W'(N_CORES - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
      en_r  <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        q[i]      <= '0;
      end
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == ST_IDLE && (MRead || MWrite)) begin
        en_r <= en;
        for (int i = 0; i < N_CORES; i++) begin
          addr_r[i] <= addr[i];
          data_r[i] <= data[i];
        end
      end
      // Memory is clocked on the falling edge, so read data is ready here.
      if (state == ST_READ && en_r[idx]) begin
        q[idx] <= data_from_mem;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    MReady      = 1'b0;
    wren        = 1'b0;
    addr_mem    = '0;
    data_to_mem = '0;
    case (state)
      ST_IDLE: begin
        MReady = 1'b1;
        if (MWrite) begin
          state_nxt = ST_WRITE;
          idx_nxt   = first_idx;
        end else if (MRead) begin
          state_nxt = ST_READ;
          idx_nxt   = first_idx;
        end
      end
      default: begin
        addr_mem    = addr_r[idx];
        data_to_mem = data_r[idx];
        wren        = (state == ST_WRITE) && en_r[idx];
        if (last_lane) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt   = next_idx;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - directed bench for memory_controller with a falling-edge DataMemory model
module tb_memory_controller;
  import memory_controller_pkg::*;

`ifdef SKIP_DISABLED_LANES_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              MRead, MWrite, MReady;
  logic [N_CORES-1:0] en;
  logic [ADDR_W-1:0] addr [N_CORES];
  logic [DATA_W-1:0] data [N_CORES];
  logic [DATA_W-1:0] q [N_CORES];
  logic [DATA_W-1:0] data_to_mem, data_from_mem;
  logic [ADDR_W-1:0] addr_mem;
  logic              wren;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_a;
  logic [DATA_W-1:0] pre_d;
  int                wr_count;

  int vectors;
  int miscompares;
  int busy;
  int w0;

  memory_controller dut (
    .clk           (clk),
    .reset         (reset),
    .MRead         (MRead),
    .MWrite        (MWrite),
    .MReady        (MReady),
    .en            (en),
    .addr          (addr),
    .data          (data),
    .q             (q),
    .data_to_mem   (data_to_mem),
    .addr_mem      (addr_mem),
    .data_from_mem (data_from_mem),
    .wren          (wren)
  );

  initial clk = 1'b0;
  always #(CLK_PERIOD / 2) clk = ~clk;

  // DataMemory stand-in, clocked on the inverted clock.
  always @(negedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (wren) begin
      mem[addr_mem] <= data_to_mem;
      wr_count      <= wr_count + 1;
    end
    data_from_mem <= mem[addr_mem];
  end

  initial begin
    #(CLK_PERIOD * 5000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    @(negedge clk);
    #1;
    pre_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] e, input logic [ADDR_W-1:0] a_base,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
    en      = e;
    data[0] = d0;
    data[1] = d1;
    data[2] = d2;
    data[3] = d3;
    for (int i = 0; i < N_CORES; i++) addr[i] = a_base + ADDR_W'(i);
  endtask

  // Called one delta after a rising edge with the controller idle.
  task automatic do_op(input bit rd, input bit wr, input bit repoke, output int n_busy);
    MRead  = rd;
    MWrite = wr;
    @(posedge clk);
    #1;
    MRead  = repoke;
    MWrite = 1'b0;
    n_busy = 0;
    while (!MReady && n_busy < 20) begin
      n_busy++;
      @(posedge clk);
      #1;
      MRead = 1'b0;
    end
    MRead = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    MRead       = 1'b0;
    MWrite      = 1'b0;
    pre_we      = 1'b0;
    pre_a       = '0;
    pre_d       = '0;
    set_req(4'b0000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_mready", MReady, 1);
    check_eq("rst_wren", wren, 0);
    check_eq("rst_addr_mem", addr_mem, 0);
    check_eq("rst_data_to_mem", data_to_mem, 0);
    for (int i = 0; i < N_CORES; i++) check_eq($sformatf("rst_q%0d", i), q[i], 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Partial-enable read
    preload(16'd11, 16'h1111);
    preload(16'd12, 16'h2222);
    set_req(4'b0110, 16'd10, 16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3);
    w0 = wr_count;
    do_op(1'b1, 1'b0, 1'b0, busy);
    check_eq("rd_busy", busy, SKIP ? 2 : 4);
    check_eq("rd_q0", q[0], 16'h0000);
    check_eq("rd_q1", q[1], 16'h1111);
    check_eq("rd_q2", q[2], 16'h2222);
    check_eq("rd_q3", q[3], 16'h0000);
    check_eq("rd_no_write", wr_count - w0, 0);

    // Full write then read-back
    set_req(4'b1111, 16'd20, 16'd9, 16'd20, 16'd55, 16'd24);
    w0 = wr_count;
    do_op(1'b0, 1'b1, 1'b0, busy);
    check_eq("wr_busy", busy, 4);
    check_eq("wr_count", wr_count - w0, 4);
    check_eq("wr_mem20", mem[20], 16'd9);
    check_eq("wr_mem21", mem[21], 16'd20);
    check_eq("wr_mem22", mem[22], 16'd55);
    check_eq("wr_mem23", mem[23], 16'd24);
    do_op(1'b1, 1'b0, 1'b0, busy);
    check_eq("rb_q0", q[0], 16'd9);
    check_eq("rb_q1", q[1], 16'd20);
    check_eq("rb_q2", q[2], 16'd55);
    check_eq("rb_q3", q[3], 16'd24);

    // Read and write together: write wins, q untouched
    set_req(4'b1111, 16'd30, 16'd1, 16'd2, 16'd3, 16'd4);
    do_op(1'b1, 1'b1, 1'b0, busy);
    check_eq("both_busy", busy, 4);
    check_eq("both_mem30", mem[30], 16'd1);
    check_eq("both_mem33", mem[33], 16'd4);
    check_eq("both_q0", q[0], 16'd9);
    check_eq("both_q3", q[3], 16'd24);

    // Request while busy is dropped
    preload(16'd40, 16'h4040);
    set_req(4'b0001, 16'd40, 16'h0, 16'h0, 16'h0, 16'h0);
    do_op(1'b1, 1'b0, 1'b1, busy);
    check_eq("busy_req_busy", busy, SKIP ? 1 : 4);
    check_eq("busy_req_q0", q[0], 16'h4040);
    check_eq("busy_req_q1", q[1], 16'd20);
    repeat (3) begin
      @(posedge clk);
      #1;
      check_eq("busy_req_stays_idle", MReady, 1);
    end

    // All lanes disabled
    preload(16'd50, 16'h5050);
    set_req(4'b0000, 16'd50, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
    w0 = wr_count;
    do_op(1'b0, 1'b1, 1'b0, busy);
    check_eq("nolane_busy", busy, SKIP ? 1 : 4);
    check_eq("nolane_mem50", mem[50], 16'h5050);
    check_eq("nolane_writes", wr_count - w0, 0);
    check_eq("nolane_q0", q[0], 16'h4040);

    // Reset at the lane 0 -> lane 1 boundary of a full write
    set_req(4'b1111, 16'd20, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3);
    MWrite = 1'b1;
    @(posedge clk);
    #1;
    MWrite = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_mready", MReady, 1);
    check_eq("abort_wren", wren, 0);
    for (int i = 0; i < N_CORES; i++) check_eq($sformatf("abort_q%0d", i), q[i], 0);
    @(posedge clk);
    #1;
    check_eq("abort_wren_later", wren, 0);
    check_eq("abort_mem20", mem[20], 16'h00A0);
    check_eq("abort_mem21", mem[21], 16'd20);
    check_eq("abort_mem22", mem[22], 16'd55);
    check_eq("abort_mem23", mem[23], 16'd24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
